// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// mole_game_ctrl : whack-a-mole round controller (levels, timing, scoring)
// Optional: MOLE_GAME_MISS_PENALTY_EN enables the miss penalty.  Rev 1.0
// ============================================================================
module mole_game_ctrl #(
  parameter int N_MOLES     = 4,
  parameter int SCORE_W     = 10,
  parameter int CLK_PER_MS  = 50000,
  parameter int EASY_MS     = 1500,
  parameter int HARD_MS     = 800,
  parameter int HELL_MS     = 400,
  parameter int GAP_MS      = 300,
  parameter int ROUND_MOLES = 20,
  parameter int HIT_PTS     = 5,
  parameter int MISS_PTS    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               level_btn,
  input  logic               start,
  input  logic [N_MOLES-1:0] switches,
  output logic [N_MOLES-1:0] mole_leds,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         level,
  output logic               game_active
);

  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int MS_W  = 16;
  localparam int IDX_W = $clog2(N_MOLES);
  localparam int CNT_W = $clog2(ROUND_MOLES + 1);
  localparam int SUM_W = SCORE_W + 5;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [2:0]         lvl_sync;
  logic [2:0]         start_sync;
  logic [N_MOLES-1:0] sw_s1, sw_s2, sw_s3;
  logic [PRE_W-1:0]   pre_cnt;
  logic [15:0]        lfsr;
  logic [MS_W-1:0]    ms_cnt;
  logic [MS_W-1:0]    up_ms;
  logic [CNT_W-1:0]   mole_cnt;

  logic               lvl_rise;
  logic               start_rise;
  logic [N_MOLES-1:0] toggles;
  logic               tick;
  logic               hit;
  logic               show_end;
  logic               last_mole;
  logic [IDX_W-1:0]   mole_idx;
  logic [4:0]         hit_n;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] next_score;
`ifdef MOLE_GAME_MISS_PENALTY_EN
  logic [4:0]         miss_n;
`endif

  // sync[0..1] are the synchroniser, sync[2] the edge-detect history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_sync   <= '0;
      start_sync <= '0;
      sw_s1      <= '0;
      sw_s2      <= '0;
      sw_s3      <= '0;
    end else begin
      lvl_sync   <= {lvl_sync[1:0], level_btn};
      start_sync <= {start_sync[1:0], start};
      sw_s1      <= switches;
      sw_s2      <= sw_s1;
      sw_s3      <= sw_s2;
    end
  end

  assign lvl_rise   = lvl_sync[1] & ~lvl_sync[2];
  assign start_rise = start_sync[1] & ~start_sync[2];
  assign toggles    = sw_s2 ^ sw_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == PRE_W'(CLK_PER_MS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == 16'd0) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign mole_idx  = IDX_W'(lfsr % 16'(N_MOLES));
  assign hit       = (state == SHOW) && ((toggles & mole_leds) != '0);
  assign show_end  = hit || (tick && (ms_cnt == up_ms - 1'b1));
  assign last_mole = (mole_cnt == CNT_W'(ROUND_MOLES));

  // Score arithmetic is signed in spirit: a set MSB of sum means below zero
  always_comb begin
    hit_n = '0;
`ifdef MOLE_GAME_MISS_PENALTY_EN
    miss_n = '0;
`endif
    for (int i = 0; i < N_MOLES; i++) begin
      if (toggles[i]) begin
        if ((state == SHOW) && mole_leds[i]) begin
          hit_n = hit_n + 5'd1;
        end
`ifdef MOLE_GAME_MISS_PENALTY_EN
        else begin
          miss_n = miss_n + 5'd1;
        end
`endif
      end
    end
    sum = SUM_W'(score) + SUM_W'(hit_n) * SUM_W'(HIT_PTS);
`ifdef MOLE_GAME_MISS_PENALTY_EN
    sum = sum - SUM_W'(miss_n) * SUM_W'(MISS_PTS);
`endif
    if (sum[SUM_W-1]) begin
      next_score = '0;
    end else if (sum > SUM_W'({SCORE_W{1'b1}})) begin
      next_score = '1;
    end else begin
      next_score = sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      level       <= 2'd0;
      score       <= '0;
      mole_leds   <= '0;
      game_active <= 1'b0;
      ms_cnt      <= '0;
      up_ms       <= '0;
      mole_cnt    <= '0;
    end else begin
      if (level == 2'd3) begin
        level <= 2'd0;
      end else if ((state == IDLE) && lvl_rise) begin
        level <= (level == 2'd2) ? 2'd0 : level + 2'd1;
      end

      case (state)
        IDLE: begin
          mole_leds   <= '0;
          game_active <= 1'b0;
          if (start_rise) begin
            score       <= '0;
            mole_cnt    <= '0;
            ms_cnt      <= '0;
            game_active <= 1'b1;
            state       <= GAP;
            case (level)
              2'd1:    up_ms <= MS_W'(HARD_MS);
              2'd2:    up_ms <= MS_W'(HELL_MS);
              default: up_ms <= MS_W'(EASY_MS);
            endcase
          end
        end
        GAP: begin
          score     <= next_score;
          mole_leds <= '0;
          if (tick) begin
            if (ms_cnt == MS_W'(GAP_MS - 1)) begin
              ms_cnt    <= '0;
              mole_cnt  <= mole_cnt + 1'b1;
              mole_leds <= N_MOLES'(1) << mole_idx;
              state     <= SHOW;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        SHOW: begin
          score <= next_score;
          if (show_end) begin
            ms_cnt    <= '0;
            mole_leds <= '0;
            if (last_mole) begin
              game_active <= 1'b0;
              state       <= DONE;
            end else begin
              state <= GAP;
            end
          end else if (tick) begin
            ms_cnt <= ms_cnt + 1'b1;
          end
        end
        DONE: begin
          mole_leds   <= '0;
          game_active <= 1'b0;
          if (start_rise) begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          mole_leds   <= '0;
          game_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mole_game_ctrl : directed bench for mole_game_ctrl (two configurations)
// Rev 1.0
// ============================================================================
module tb_mole_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lvl_a = 1'b0, start_a = 1'b0;
  logic [3:0] sw_a = 4'd0;
  logic [3:0] leds_a;
  logic [9:0] score_a;
  logic [1:0] level_a;
  logic       act_a;
  logic       lvl_b = 1'b0, start_b = 1'b0;
  logic [3:0] sw_b = 4'd0;
  logic [3:0] leds_b;
  logic [3:0] score_b;
  logic [1:0] level_b;
  logic       act_b;

  int total = 0;
  int bad   = 0;

`ifdef MOLE_GAME_MISS_PENALTY_EN
  localparam int MISS1 = 3;
  localparam int MISS2 = 0;
`else
  localparam int MISS1 = 5;
  localparam int MISS2 = 5;
`endif

  always #5 clk = ~clk;

  mole_game_ctrl #(
    .N_MOLES(4), .SCORE_W(10), .CLK_PER_MS(4), .EASY_MS(3), .HARD_MS(2),
    .HELL_MS(1), .GAP_MS(2), .ROUND_MOLES(3), .HIT_PTS(5), .MISS_PTS(2)
  ) dut_a (
    .clk(clk), .rst(rst), .level_btn(lvl_a), .start(start_a),
    .switches(sw_a), .mole_leds(leds_a), .score(score_a),
    .level(level_a), .game_active(act_a)
  );

  mole_game_ctrl #(
    .N_MOLES(4), .SCORE_W(4), .CLK_PER_MS(4), .EASY_MS(3), .HARD_MS(2),
    .HELL_MS(1), .GAP_MS(2), .ROUND_MOLES(3), .HIT_PTS(7), .MISS_PTS(2)
  ) dut_b (
    .clk(clk), .rst(rst), .level_btn(lvl_b), .start(start_b),
    .switches(sw_b), .mole_leds(leds_b), .score(score_b),
    .level(level_b), .game_active(act_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur_leds(input bit b);
    return b ? leds_b : leds_a;
  endfunction

  function automatic logic [31:0] cur_score(input bit b);
    return b ? 32'(score_b) : 32'(score_a);
  endfunction

  function automatic logic cur_act(input bit b);
    return b ? act_b : act_a;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    cyc(2);
    start_a = 1'b0;
    start_b = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_lvl_a;
    lvl_a = 1'b1;
    cyc(2);
    lvl_a = 1'b0;
    cyc(4);
  endtask

  task automatic wait_leds(input bit b, input bit lit);
    int n = 0;
    while (((cur_leds(b) != 4'd0) != lit) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk("wait_leds", 32'(n < 200), 32'd1);
  endtask

  task automatic count_while(input bit lit, output int n);
    n = 0;
    while (((leds_a != 4'd0) == lit) && act_a && (n < 100)) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Toggle the lit switch and watch the score land on the third edge
  task automatic hit(input bit b, input int old_s, input int new_s, input bit act_after);
    logic [3:0] mask;
    wait_leds(b, 1'b1);
    mask = cur_leds(b);
    if (b) sw_b = sw_b ^ mask; else sw_a = sw_a ^ mask;
    cyc(1);
    chk("hit_e1_score", cur_score(b), 32'(old_s));
    chk("hit_e1_leds", 32'(cur_leds(b)), 32'(mask));
    cyc(1);
    chk("hit_e2_score", cur_score(b), 32'(old_s));
    chk("hit_e2_leds", 32'(cur_leds(b)), 32'(mask));
    cyc(1);
    chk("hit_e3_score", cur_score(b), 32'(new_s));
    chk("hit_e3_leds", 32'(cur_leds(b)), 32'd0);
    chk("hit_e3_active", 32'(cur_act(b)), 32'(act_after));
  endtask

  initial begin
    int n;
    logic [3:0] m, p1, p2;

    cyc(3);
    chk("rst_leds", 32'(leds_a), 32'd0);
    chk("rst_score", 32'(score_a), 32'd0);
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_active", 32'(act_a), 32'd0);
    rst = 1'b0;
    cyc(2);

    pulse_lvl_a(); chk("level_1", 32'(level_a), 32'd1);
    pulse_lvl_a(); chk("level_2", 32'(level_a), 32'd2);
    pulse_lvl_a(); chk("level_0", 32'(level_a), 32'd0);

    // Round 1: no switch activity, check lit/dark durations
    pulse_start(1'b0);
    wait_leds(1'b0, 1'b1);
    chk("r1_onehot", 32'($onehot(leds_a)), 32'd1);
    count_while(1'b1, n); chk("r1_lit1", n, 12);
    count_while(1'b0, n); chk("r1_gap1", n, 8);
    chk("r1_onehot2", 32'($onehot(leds_a)), 32'd1);
    count_while(1'b1, n); chk("r1_lit2", n, 12);
    count_while(1'b0, n); chk("r1_gap2", n, 8);
    count_while(1'b1, n); chk("r1_lit3", n, 12);
    chk("r1_done_active", 32'(act_a), 32'd0);
    chk("r1_done_score", 32'(score_a), 32'd0);
    cyc(20);
    chk("r1_done_leds", 32'(leds_a), 32'd0);
    chk("r1_done_hold", 32'(act_a), 32'd0);
    pulse_start(1'b0);
    cyc(20);
    chk("done_to_idle_noround", 32'(act_a), 32'd0);

    // Round 2: hit, ignored level press, misses with clamping
    pulse_start(1'b0);
    hit(1'b0, 0, 5, 1'b1);
    wait_leds(1'b0, 1'b1);
    lvl_a = 1'b1;
    cyc(2);
    lvl_a = 1'b0;
    cyc(3);
    chk("r2_level_frozen", 32'(level_a), 32'd0);
    chk("r2_still_show", 32'(leds_a != 4'd0), 32'd1);
    m  = ~leds_a;
    p1 = m & (~m + 4'd1);
    sw_a = sw_a ^ p1;
    cyc(3);
    chk("r2_miss1", 32'(score_a), 32'(MISS1));
    wait_leds(1'b0, 1'b0);
    wait_leds(1'b0, 1'b1);
    m  = ~leds_a;
    p1 = m & (~m + 4'd1);
    m  = m & ~p1;
    p2 = m & (~m + 4'd1);
    sw_a = sw_a ^ (p1 | p2);
    cyc(3);
    chk("r2_miss2_clamp", 32'(score_a), 32'(MISS2));
    n = 0;
    while (act_a && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk("r2_done_to", 32'(n < 200), 32'd1);
    chk("r2_done_score", 32'(score_a), 32'(MISS2));

    // Round 3: asynchronous reset in the middle of a SHOW
    pulse_start(1'b0);
    pulse_start(1'b0);
    hit(1'b0, 0, 5, 1'b1);
    hit(1'b0, 5, 10, 1'b1);
    wait_leds(1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_leds", 32'(leds_a), 32'd0);
    chk("arst_score", 32'(score_a), 32'd0);
    chk("arst_active", 32'(act_a), 32'd0);
    chk("arst_level", 32'(level_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);

    // Narrow score: saturation at 15
    pulse_start(1'b1);
    hit(1'b1, 0, 7, 1'b1);
    hit(1'b1, 7, 14, 1'b1);
    hit(1'b1, 14, 15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
